logic_bist: RTL and testbench
=============================

Name: logic_bist

Overview:
- Self-test sequencer and checker for the 2-input, 4-output gate unit (inputs A, B; outputs Y0..Y3).
- Drives the four input vectors onto the unit, samples its outputs after a settle interval, and compares them against the expected truth table.
- Reports pass/fail through a start/busy/done handshake.
- Sits beside the gate unit on the board; replaces bench-only stimulus with an on-chip check.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held before sampling (legal range 1..255).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous reset, active-low.
- START  input  1  begin a test run; honoured only in IDLE.
- A  output  1  stimulus to the gate unit A input.
- B  output  1  stimulus to the gate unit B input.
- Y  input  4  gate unit outputs {Y3,Y2,Y1,Y0}.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse when a run completes.
- PASS  output  1  high after a run with zero mismatches; held until the next accepted START.
- ERR_CNT  output  3  number of failing vectors in the run (0..4).
- FAIL_MASK  output  4  bit v set when vector v mismatched.
- FAIL_BITS  output  4  OR over all vectors of (Y XOR expected); identifies faulty outputs.

Behaviour:
- One clock; reset is asynchronous and active-low. CLK and RST_N as named above; polarity and synchronicity fixed.
- Reset values: A=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_MASK=0, FAIL_BITS=0, state IDLE, vector index 0, hold counter 0.
- Vector order is index v = {A,B}: 0=00, 1=01, 2=10, 3=11.
- Expected outputs: Y0=A&B, Y1=A|B, Y2=A^B, Y3=~(A&B).
  - Expected Y per vector: v0=1000, v1=1110, v2=1110, v3=0011.
- FSM states: IDLE, DRIVE, FIN.
- IDLE: A=B=0.
  - START=1 sampled → next cycle enters DRIVE with v=0, counter=0, BUSY=1.
  - ERR_CNT, FAIL_MASK, FAIL_BITS and PASS are cleared on that same edge.
- DRIVE: A/B are registered from v.
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES-1, Y is compared on that edge:
    - On mismatch: FAIL_MASK[v] set, ERR_CNT incremented, FAIL_BITS |= Y^exp.
  - Counter then returns to 0 and v advances; after v=3 the FSM goes to FIN.
- FIN (one cycle): DONE=1, BUSY=0, PASS=(ERR_CNT==0), A=B=0; then returns to IDLE.
- Latency: START sampled at edge 0 → DONE high during cycle 4*HOLD_CYCLES+1.
- START while BUSY or in FIN is ignored and has no effect on the current run.
- Results remain stable in IDLE until the next accepted START.
- RST_N low at any time, including mid-run: immediate return to reset values; no DONE pulse.
- HOLD_CYCLES=1: each vector is held exactly one cycle; Y is sampled at the end of that cycle.
- ERR_CNT cannot exceed 4 in single-pass mode.

Optional Feature:
- Macro LOGIC_BIST_LOOP_EN.
- Defined: at the end of vector 3, if START is still high, the FSM pulses DONE for one cycle and restarts at v=0 without passing through IDLE.
  - Results accumulate: FAIL_MASK and FAIL_BITS are sticky, and ERR_CNT saturates at 7.
  - PASS is updated on each DONE to reflect all passes since the accepted START.
  - START low at the end of a pass → normal FIN then IDLE.
- Not defined: single pass only; START level at the end of a run is ignored.

Decomposition:
- Package logic_bist_pkg holds:
  - state enum {IDLE, DRIVE, FIN};
  - vector-count constant NUM_VEC=4;
  - expected-output table EXP[0..3];
  - ERR_CNT width constant.
- One sub-module, logic_bist_cmp: combinational compare of Y against EXP[v], producing a mismatch flag and a 4-bit diff vector.
- The FSM, counters and result registers stay in logic_bist.

Test Plan:
- Correct gate model, HOLD_CYCLES=4, START pulse at cycle 0 → BUSY cycles 1-16; DONE at cycle 17; PASS=1, ERR_CNT=0, FAIL_MASK=0000, FAIL_BITS=0000.
- Y3 stuck at 0 → ERR_CNT=3, FAIL_MASK=0111, FAIL_BITS=1000, PASS=0.
- Y2 stuck at 1 → ERR_CNT=2, FAIL_MASK=1001, FAIL_BITS=0100, PASS=0.
- START re-pulsed at cycle 6 during a run → ignored; DONE still at cycle 17 with unchanged results.
- RST_N low at cycle 9, released at cycle 11 → all outputs 0, no DONE; a new START runs a clean pass with PASS=1.
- With LOGIC_BIST_LOOP_EN, START held high for 3 passes, Y1 stuck at 0 → DONE at cycles 17, 33, 49.
  - Final ERR_CNT=7 (saturated from 9), FAIL_MASK=1110, FAIL_BITS=0010.

Source files
------------

// File: rtl/logic_bist_pkg.sv
// logic_bist_pkg: shared types and constants for the gate-unit self-test.
//   state_e : sequencer states (IDLE, DRIVE, FIN)
//   NUM_VEC : number of stimulus vectors, indexed v = {A,B}
//   ERR_W   : width of the failing-vector counter
//   ERR_MAX : saturation value of the failing-vector counter
//   EXP     : expected {Y3,Y2,Y1,Y0} per vector, where
//             Y0=A&B, Y1=A|B, Y2=A^B, Y3=~(A&B)
package logic_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam int NUM_VEC = 4;
  localparam int ERR_W   = 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // EXP[0]=1000, EXP[1]=1110, EXP[2]=1110, EXP[3]=0011
  localparam logic [NUM_VEC-1:0][3:0] EXP = {4'b0011, 4'b1110, 4'b1110, 4'b1000};

endpackage

// File: rtl/logic_bist_cmp.sv
// logic_bist_cmp: combinational compare of the gate-unit outputs against
// the expected truth-table row for the vector currently driven.
//   vec      : current vector index {A,B}
//   y        : observed gate-unit outputs {Y3,Y2,Y1,Y0}
//   mismatch : high when any output differs from the expected row
//   diff     : per-output difference (y XOR expected)
module logic_bist_cmp
  import logic_bist_pkg::*;
(
  input  logic [1:0] vec,
  input  logic [3:0] y,
  output logic       mismatch,
  output logic [3:0] diff
);

  assign diff     = y ^ EXP[vec];
  assign mismatch = |diff;

endmodule

// File: rtl/logic_bist.sv
// logic_bist: on-chip self-test sequencer for the 2-input, 4-output gate unit.
// Drives the four {A,B} vectors, holds each for HOLD_CYCLES clocks, samples
// Y on the last hold edge and accumulates mismatch results.
//
// Ports:
//   CLK, RST_N     : clock (rising edge), asynchronous active-low reset
//   START          : request a run; accepted only in IDLE
//   A, B           : registered stimulus to the gate unit
//   Y              : gate-unit outputs {Y3,Y2,Y1,Y0}
//   BUSY           : high while vectors are being applied
//   DONE           : one-cycle pulse at the end of a run (or of each pass)
//   PASS           : run finished with no mismatches; held until next START
//   ERR_CNT        : number of failing vectors (saturates at ERR_MAX)
//   FAIL_MASK      : bit v set when vector v mismatched
//   FAIL_BITS      : OR of (Y XOR expected) over all vectors
//   state_dbg      : current sequencer state (state_e encoding)
//
// Handshake: START is a level sampled on the rising edge while in IDLE; the
// edge that samples it raises BUSY and clears the results. BUSY stays high
// until the edge that raises DONE; DONE lasts exactly one cycle, and the
// results are valid from that cycle until the next accepted START.
//
// Build option LOGIC_BIST_LOOP_EN: if START is still high when vector 3 is
// sampled, DONE pulses and the run restarts at vector 0 with results
// accumulating (sticky masks, saturating count). Without it a run is a
// single pass and START is ignored outside IDLE.
module logic_bist
  import logic_bist_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic             A,
  output logic             B,
  input  logic [3:0]       Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_MASK,
  output logic [3:0]       FAIL_BITS,
  output logic [1:0]       state_dbg
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e           state;
  logic [1:0]       vec;
  logic [7:0]       hold_cnt;
  logic             mismatch;
  logic [3:0]       diff;
  logic             sample;
  logic             loop_req;
  logic [ERR_W-1:0] err_next;
  logic [3:0]       mask_next;
  logic [3:0]       bits_next;

  logic_bist_cmp u_cmp (
    .vec      (vec),
    .y        (Y),
    .mismatch (mismatch),
    .diff     (diff)
  );

  assign sample    = (hold_cnt == HOLD_LAST);
  assign state_dbg = state;

`ifdef LOGIC_BIST_LOOP_EN
  assign loop_req = START;
`else
  assign loop_req = 1'b0;
`endif

  // Result registers as they will be after the current sample edge.
  always_comb begin
    err_next  = ERR_CNT;
    mask_next = FAIL_MASK;
    bits_next = FAIL_BITS;
    if (mismatch) begin
      if (ERR_CNT != ERR_MAX) err_next = ERR_CNT + 1'b1;
      mask_next[vec] = 1'b1;
      bits_next      = FAIL_BITS | diff;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      vec       <= 2'd0;
      hold_cnt  <= 8'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= 4'd0;
      FAIL_BITS <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          A    <= 1'b0;
          B    <= 1'b0;
          if (START) begin
            state     <= DRIVE;
            vec       <= 2'd0;
            hold_cnt  <= 8'd0;
            BUSY      <= 1'b1;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_MASK <= 4'd0;
            FAIL_BITS <= 4'd0;
          end
        end

        DRIVE: begin
          DONE <= 1'b0;
          if (sample) begin
            ERR_CNT   <= err_next;
            FAIL_MASK <= mask_next;
            FAIL_BITS <= bits_next;
            hold_cnt  <= 8'd0;
            if (vec == 2'(NUM_VEC - 1)) begin
              // End of a pass: report, then either loop or finish.
              DONE <= 1'b1;
              PASS <= (err_next == '0);
              vec  <= 2'd0;
              A    <= 1'b0;
              B    <= 1'b0;
              if (!loop_req) begin
                state <= FIN;
                BUSY  <= 1'b0;
              end
            end else begin
              vec <= vec + 2'd1;
              {A, B} <= vec + 2'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_bist.sv
// tb_logic_bist: self-checking bench for logic_bist with HOLD_CYCLES=4.
// A behavioural gate unit with selectable stuck-at faults answers the DUT's
// stimulus; expected results are pushed to a queue when a run is started and
// popped when DONE is observed.
module tb_logic_bist;

  localparam int HOLD = 4;
  localparam int RUN_DONE = 4 * HOLD + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b;
  logic [3:0] y;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask, fail_bits;
  logic [1:0] state_dbg;

  int fault;
  int n_checks;
  int n_errors;

  logic [11:0] exp_q[$];

  logic_bist #(.HOLD_CYCLES(HOLD)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .A         (a),
    .B         (b),
    .Y         (y),
    .BUSY      (busy),
    .DONE      (done),
    .PASS      (pass),
    .ERR_CNT   (err_cnt),
    .FAIL_MASK (fail_mask),
    .FAIL_BITS (fail_bits),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate-unit model
  function automatic logic [3:0] ideal(input logic [1:0] v);
    logic ia, ib;
    ia = v[1];
    ib = v[0];
    return {~(ia & ib), ia ^ ib, ia | ib, ia & ib};
  endfunction

  function automatic logic [3:0] faulty(input logic [3:0] yi, input int f);
    logic [3:0] r;
    r = yi;
    case (f)
      1: r[3] = 1'b0;
      2: r[2] = 1'b1;
      3: r[1] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  always_comb y = faulty(ideal({a, b}), fault);

  // expected {pass, err_cnt, fail_mask, fail_bits} after 'passes' passes
  function automatic logic [11:0] model(input int f, input int passes);
    int         errs;
    logic [3:0] m, bits, d;
    errs = 0;
    m    = 4'd0;
    bits = 4'd0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        d = faulty(ideal(2'(v)), f) ^ ideal(2'(v));
        if (d != 4'd0) begin
          errs++;
          m[v] = 1'b1;
          bits = bits | d;
        end
      end
    end
    if (errs > 7) errs = 7;
    return {(errs == 0), 3'(errs), m, bits};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [11:0] e);
    check({tag, "_pass"}, 32'(pass), 32'(e[11]));
    check({tag, "_err"}, 32'(err_cnt), 32'(e[10:8]));
    check({tag, "_mask"}, 32'(fail_mask), 32'(e[7:4]));
    check({tag, "_bits"}, 32'(fail_bits), 32'(e[3:0]));
  endtask

  // Single run: START pulse sampled at edge 0; c counts the cycle observed
  // at each falling edge (cycle c follows edge c-1).
  task automatic run_check(input string tag, input int f, input bit repulse);
    int          c;
    bit          busy_ok;
    logic [11:0] e;
    fault = f;
    exp_q.push_back(model(f, 1));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1;
    busy_ok = 1'b1;
    while (!done && c < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (repulse && c == 6) start = 1'b1;
      if (c == 7) start = 1'b0;
      @(negedge clk);
      c++;
    end
    check({tag, "_done_cycle"}, 32'(c), 32'(RUN_DONE));
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_fin"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check_results(tag, e);
    repeat (3) @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check_results({tag, "_idle"}, e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    fault    = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {a, b, busy, done, pass, err_cnt, fail_mask, fail_bits}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_check("good", 0, 1'b0);
    run_check("y3_sa0", 1, 1'b0);
    run_check("y2_sa1", 2, 1'b0);
    run_check("repulse", 1, 1'b1);

    // reset mid-run: no DONE, all outputs cleared, then a clean run
    begin
      int c;
      bit seen_done;
      fault = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      seen_done = 1'b0;
      for (c = 1; c < 30; c++) begin
        if (c == 9) rst_n = 1'b0;
        if (c == 10)
          check("midrst_outs", {a, b, busy, done, pass, err_cnt, fail_mask, fail_bits}, 32'd0);
        if (c == 11) rst_n = 1'b1;
        if (done) seen_done = 1'b1;
        @(negedge clk);
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
      check("midrst_idle", 32'(state_dbg), 32'd0);
    end
    run_check("after_rst", 0, 1'b0);

`ifdef LOGIC_BIST_LOOP_EN
    // START held for three passes with Y1 stuck at 0
    begin
      int c;
      int npass;
      logic [11:0] e;
      fault = 3;
      npass = 0;
      for (int p = 1; p <= 3; p++) exp_q.push_back(model(3, p));
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      c = 1;
      while (c < 60 && npass < 3) begin
        if (c == 34) start = 1'b0;
        if (done) begin
          npass++;
          check($sformatf("loop_done_cycle%0d", npass), 32'(c), 32'(16 * npass + 1));
          e = exp_q.pop_front();
          check_results($sformatf("loop_p%0d", npass), e);
        end
        @(negedge clk);
        c++;
      end
      check("loop_passes", 32'(npass), 32'd3);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("loop_idle", 32'(state_dbg), 32'd0);
    end
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
